// File: rtl/scaler_frame_ctrl.sv
// Frame sequencer for a video scaler: accepts a frame configuration, starts the scaler,
// pulls output pixels with per-line horizontal blanking, and reports done or timeout.
module scaler_frame_ctrl #(
  parameter int unsigned INPUT_X_RES_WIDTH  = 11,
  parameter int unsigned INPUT_Y_RES_WIDTH  = 11,
  parameter int unsigned OUTPUT_X_RES_WIDTH = 11,
  parameter int unsigned OUTPUT_Y_RES_WIDTH = 11,
  parameter int unsigned TIMEOUT            = 65535
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [INPUT_X_RES_WIDTH-1:0]  cfg_in_x_res,
  input  logic [INPUT_Y_RES_WIDTH-1:0]  cfg_in_y_res,
  input  logic [OUTPUT_X_RES_WIDTH-1:0] cfg_out_x_res,
  input  logic [OUTPUT_Y_RES_WIDTH-1:0] cfg_out_y_res,
  input  logic [17:0]                   cfg_x_scale,
  input  logic [17:0]                   cfg_y_scale,
  input  logic [15:0]                   cfg_hblank,
  output logic [INPUT_X_RES_WIDTH-1:0]  sc_input_x_res,
  output logic [INPUT_Y_RES_WIDTH-1:0]  sc_input_y_res,
  output logic [OUTPUT_X_RES_WIDTH-1:0] sc_output_x_res,
  output logic [OUTPUT_Y_RES_WIDTH-1:0] sc_output_y_res,
  output logic [17:0]                   sc_x_scale,
  output logic [17:0]                   sc_y_scale,
  output logic                          sc_start,
  output logic                          sc_next_dout,
  input  logic                          sc_dout_valid,
  output logic [OUTPUT_X_RES_WIDTH-1:0] out_x,
  output logic [OUTPUT_Y_RES_WIDTH-1:0] out_y,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          frame_error
);

  localparam int unsigned TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned HB_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    ACTIVE = 3'd2,
    HBLANK = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic [HB_W-1:0]               hblank_q;
  logic [HB_W-1:0]               hb_cnt_q, hb_cnt_d;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic [OUTPUT_X_RES_WIDTH-1:0] out_x_d;
  logic [OUTPUT_Y_RES_WIDTH-1:0] out_y_d;
  logic                          cfg_load;
  logic                          pix;
  logic                          line_end;
  logic                          frame_end;

  // Next-state, counter and load decisions.
  always_comb begin
    state_d  = state_q;
    out_x_d  = out_x;
    out_y_d  = out_y;
    to_cnt_d = to_cnt_q;
    hb_cnt_d = hb_cnt_q;
    cfg_load = 1'b0;

    // In-flight pixels landing during blanking are still counted.
    pix       = sc_dout_valid && ((state_q == ACTIVE) || (state_q == HBLANK));
    line_end  = (out_x == sc_output_x_res);
    frame_end = line_end && (out_y == sc_output_y_res);

    if (pix) begin
      to_cnt_d = '0;
      if (line_end) begin
        out_x_d = '0;
        if (!frame_end) begin
          out_y_d = out_y + OUTPUT_Y_RES_WIDTH'(1);
        end
      end else begin
        out_x_d = out_x + OUTPUT_X_RES_WIDTH'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          cfg_load = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        out_x_d  = '0;
        out_y_d  = '0;
        to_cnt_d = '0;
        hb_cnt_d = '0;
        state_d  = ACTIVE;
      end
      ACTIVE: begin
        if (pix && frame_end) begin
          state_d = DONE;
        end else if (pix && line_end && (hblank_q != '0)) begin
          state_d  = HBLANK;
          hb_cnt_d = '0;
        end else if (!pix) begin
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            state_d = ERROR;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      HBLANK: begin
        if (pix && frame_end) begin
          state_d = DONE;
        end else if (hb_cnt_q == (hblank_q - HB_W'(1))) begin
          state_d = ACTIVE;
        end else begin
          hb_cnt_d = hb_cnt_q + HB_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, latched configuration and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      hblank_q        <= '0;
      hb_cnt_q        <= '0;
      to_cnt_q        <= '0;
      out_x           <= '0;
      out_y           <= '0;
      sc_input_x_res  <= '0;
      sc_input_y_res  <= '0;
      sc_output_x_res <= '0;
      sc_output_y_res <= '0;
      sc_x_scale      <= '0;
      sc_y_scale      <= '0;
      cfg_ready       <= 1'b1;
      busy            <= 1'b0;
      sc_start        <= 1'b0;
      sc_next_dout    <= 1'b0;
      frame_done      <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      state_q  <= state_d;
      hb_cnt_q <= hb_cnt_d;
      to_cnt_q <= to_cnt_d;
      out_x    <= out_x_d;
      out_y    <= out_y_d;
      if (cfg_load) begin
        sc_input_x_res  <= cfg_in_x_res;
        sc_input_y_res  <= cfg_in_y_res;
        sc_output_x_res <= cfg_out_x_res;
        sc_output_y_res <= cfg_out_y_res;
        sc_x_scale      <= cfg_x_scale;
        sc_y_scale      <= cfg_y_scale;
        hblank_q        <= cfg_hblank;
      end
      // Status flops are decoded from the next state so they align with the state register.
      cfg_ready    <= (state_d == IDLE);
      busy         <= (state_d != IDLE);
      sc_start     <= (state_d == START);
      sc_next_dout <= (state_d == ACTIVE);
      frame_done   <= (state_d == DONE);
      frame_error  <= (state_d == ERROR);
    end
  end

endmodule
